dcache_dm_wt: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the pipeline's memory stage and the multi-cycle main data memory.
- Replaces the flat single-cycle data memory and its ad-hoc cache-hit inputs.
- Handles RV32I byte, half and word loads and stores, using real byte offsets from the address.
- Stalls the pipeline during refills and write-throughs.

---
 rtl/dcache_dm_wt.sv | 219 +++++++++++++++++++++
 tb/tb_dcache_dm_wt.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Sits between the pipeline memory stage and a multi-cycle backing memory.
// Each line holds one 32-bit word. Loads that hit return data in the same
// cycle. Load misses refill the line and then hit on the following cycle.
// Stores always write through to memory. A store that hits also updates the
// selected byte lanes of the cached word.
// Optional build macro DCACHE_PERF_COUNTERS_EN adds two saturating counters,
// perf_hits and perf_misses.
module dcache_dm_wt #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [2:0]            cpu_funct3,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  cpu_misaligned,
  output logic                  cache_hit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
`ifdef DCACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]           perf_hits,
  output logic [31:0]           perf_misses
`endif
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t                state, state_nx;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [1:0]            off;
  logic                  f3_load, f3_store, align_bad, st_go, ld_go;
  logic [DATA_WIDTH-1:0] st_lanes;
  logic [3:0]            st_strb;

  // Outstanding memory request. It is captured when leaving IDLE, so the
  // memory interface stays stable for the whole transfer.
  logic [ADDR_WIDTH-3:0] req_word;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [3:0]            req_wstrb;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;

  // Select the addressed byte or half of a word, then sign- or zero-extend it.
  function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [2:0] f3,
                                                         input logic [1:0] o,
                                                         input logic [DATA_WIDTH-1:0] word);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    byte_s = word[{o, 3'b000} +: 8];
    half_s = o[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extract = DATA_WIDTH'(byte_s);
      3'b001:  load_extract = DATA_WIDTH'(half_s);
      3'b010:  load_extract = word;
      3'b100:  load_extract = DATA_WIDTH'($unsigned(byte_s));
      3'b101:  load_extract = DATA_WIDTH'($unsigned(half_s));
      default: load_extract = '0;
    endcase
  endfunction

  // Byte-lane enables for a store of the given size at the given offset.
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] o);
    case (f3)
      3'b000:  store_strb = 4'b0001 << o;
      3'b001:  store_strb = 4'b0011 << o;
      3'b010:  store_strb = 4'b1111;
      default: store_strb = 4'b0000;
    endcase
  endfunction

  // Move LSB-justified store data into its byte lanes. Unused lanes are zero.
  function automatic logic [DATA_WIDTH-1:0] store_lanes(input logic [2:0] f3,
                                                        input logic [1:0] o,
                                                        input logic [DATA_WIDTH-1:0] w);
    case (f3)
      3'b000:  store_lanes = (w & DATA_WIDTH'(8'hFF)) << {o, 3'b000};
      3'b001:  store_lanes = (w & DATA_WIDTH'(16'hFFFF)) << {o, 3'b000};
      default: store_lanes = w;
    endcase
  endfunction

  assign idx       = cpu_addr[INDEX_BITS+1:2];
  assign tag       = cpu_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign off       = cpu_addr[1:0];
  assign req_idx   = req_word[INDEX_BITS-1:0];
  assign req_tag   = req_word[ADDR_WIDTH-3:INDEX_BITS];

  assign f3_load   = cpu_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign f3_store  = cpu_funct3 inside {3'b000, 3'b001, 3'b010};
  assign align_bad = ((cpu_funct3 == 3'b001 || cpu_funct3 == 3'b101) && off[0]) ||
                     (cpu_funct3 == 3'b010 && off != 2'b00);
  assign st_go     = cpu_we && f3_store && !align_bad;
  assign ld_go     = !cpu_we && cpu_re && f3_load && !align_bad;

  assign cpu_misaligned = align_bad && (cpu_we ? f3_store : (cpu_re && f3_load));
  assign cache_hit      = valid[idx] && (tag_mem[idx] == tag);
  assign st_lanes       = store_lanes(cpu_funct3, off, cpu_wdata);
  assign st_strb        = store_strb(cpu_funct3, off);

  assign mem_addr  = {req_word, 2'b00};
  assign mem_wdata = req_wdata;
  assign mem_wstrb = (state == WRITE) ? req_wstrb : 4'b0000;

  // Next-state logic, stall and load data. The pipeline side is forced quiet
  // while reset is held.
  always_comb begin
    state_nx  = state;
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (st_go) begin
          cpu_stall = 1'b1;
          state_nx  = WRITE;
        end else if (ld_go) begin
          if (cache_hit) begin
            cpu_rdata = load_extract(cpu_funct3, off, data_mem[idx]);
          end else begin
            cpu_stall = 1'b1;
            state_nx  = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req   = 1'b1;
        cpu_stall = 1'b1;
        if (mem_ready) state_nx = IDLE;
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        cpu_stall = !mem_ready;
        if (mem_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (!rst_n) begin
      cpu_stall = 1'b0;
      cpu_rdata = '0;
    end
  end

  // State register. An asynchronous reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Valid bits. A line becomes valid only when its refill completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           valid          <= '0;
    else if (state == REFILL && mem_ready) valid[req_idx] <= 1'b1;
  end

  // Request capture, store-hit lane merge and refill write. This storage is
  // not reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && (st_go || (ld_go && !cache_hit))) begin
      req_word  <= cpu_addr[ADDR_WIDTH-1:2];
      req_wdata <= st_lanes;
      req_wstrb <= st_strb;
    end
    if (state == IDLE && st_go && cache_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (st_strb[i]) data_mem[idx][8*i +: 8] <= st_lanes[8*i +: 8];
      end
    end
    if (state == REFILL && mem_ready) begin
      data_mem[req_idx] <= mem_rdata;
      tag_mem[req_idx]  <= req_tag;
    end
  end

`ifdef DCACHE_PERF_COUNTERS_EN
  logic refill_done;

  // Saturating hit and miss counters. A load released right after a refill
  // counts only as a miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refill_done <= 1'b0;
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      refill_done <= (state == REFILL) && mem_ready;
      if (state == IDLE && ld_go && cache_hit && !refill_done && perf_hits != '1)
        perf_hits <= perf_hits + 32'd1;
      if (state == IDLE && state_nx == REFILL && perf_misses != '1)
        perf_misses <= perf_misses + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dcache_dm_wt.sv
// Self-checking bench for dcache_dm_wt.
// The bench models memory as a sparse word array. It models the cache as the
// word address resident in each index. A negedge compare process checks the
// DUT outputs against that model on every cycle of every access.
module tb_dcache_dm_wt;
  localparam int LAT = 3;

  logic        clk, rst_n;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0]  cpu_funct3;
  logic        cpu_stall, cpu_misaligned, cache_hit;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;

  dcache_dm_wt dut (
    .clk(clk), .rst_n(rst_n), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_misaligned(cpu_misaligned),
    .cache_hit(cache_hit), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing memory model. Unwritten words hold an address-derived pattern.
  logic [31:0] mem_model [logic [31:0]];
  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Cache model: which word address each index currently holds.
  bit          res_v [8];
  logic [31:0] res_a [8];

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] o,
                                             input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * o)) & 32'hFF;
    h = (w >> (16 * o[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b010:  return w;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'h0;
    endcase
  endfunction

  // Memory responder: pulses mem_ready on the (LAT+1)th cycle of a request.
  int rsp_cnt = 0;
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0BAD_0BAD;
  end
  always @(posedge clk) begin
    #2;
    if (mem_req) rsp_cnt++;
    else         rsp_cnt = 0;
    mem_ready = mem_req && (rsp_cnt == LAT + 1);
    mem_rdata = mem_ready ? rd_mem(mem_addr) : 32'h0BAD_0BAD;
  end

  typedef enum {K_IDLE, K_HIT, K_MISS, K_ST, K_MIS, K_NOP} kind_t;
  kind_t       t_kind;
  bit          t_active = 0;
  bit          t_resident;
  int          t_k, t_stalls;
  logic [31:0] t_addr, t_exp_rdata, t_exp_wdata;
  logic [3:0]  t_exp_wstrb;
  logic [31:0] got_rdata, got_wdata;
  logic [3:0]  got_wstrb;

  // Compare process: checks every cycle of the current access against the model.
  always @(negedge clk) begin
    if (t_active) begin
      if (cpu_stall) t_stalls++;
      case (t_kind)
        K_HIT: begin
          chk("hit_stall", cpu_stall, 0);
          chk("hit_rdata", cpu_rdata, t_exp_rdata);
          chk("hit_cache_hit", cache_hit, 1);
          chk("hit_mem_req", mem_req, 0);
          got_rdata = cpu_rdata;
        end
        K_MISS: begin
          if (t_k == 0) begin
            chk("miss_stall_first", cpu_stall, 1);
            chk("miss_cache_hit_first", cache_hit, 0);
            chk("miss_mem_req_first", mem_req, 0);
          end else if (t_k <= LAT + 1) begin
            chk("refill_stall", cpu_stall, 1);
            chk("refill_mem_req", mem_req, 1);
            chk("refill_mem_we", mem_we, 0);
            chk("refill_mem_addr", mem_addr, t_addr);
          end else begin
            chk("release_stall", cpu_stall, 0);
            chk("release_mem_req", mem_req, 0);
            chk("release_cache_hit", cache_hit, 1);
            chk("release_rdata", cpu_rdata, t_exp_rdata);
            got_rdata = cpu_rdata;
          end
        end
        K_ST: begin
          if (t_k == 0) begin
            chk("store_stall_first", cpu_stall, 1);
            chk("store_mem_req_first", mem_req, 0);
            chk("store_cache_hit", cache_hit, t_resident);
            chk("store_rdata", cpu_rdata, 0);
          end else begin
            chk("write_mem_req", mem_req, 1);
            chk("write_mem_we", mem_we, 1);
            chk("write_mem_addr", mem_addr, t_addr);
            chk("write_mem_wstrb", mem_wstrb, t_exp_wstrb);
            chk("write_mem_wdata", mem_wdata, t_exp_wdata);
            chk("write_stall", cpu_stall, t_k != LAT + 1);
            if (t_k == 1) begin
              got_wstrb = mem_wstrb;
              got_wdata = mem_wdata;
            end
          end
        end
        K_MIS: begin
          chk("misaligned_flag", cpu_misaligned, 1);
          chk("misaligned_stall", cpu_stall, 0);
          chk("misaligned_rdata", cpu_rdata, 0);
          chk("misaligned_mem_req", mem_req, 0);
        end
        default: begin
          chk("quiet_misaligned", cpu_misaligned, 0);
          chk("quiet_stall", cpu_stall, 0);
          chk("quiet_rdata", cpu_rdata, 0);
          chk("quiet_mem_req", mem_req, 0);
        end
      endcase
      t_k++;
    end
  end

  // One pipeline access. Called at posedge+1. It holds the request for as many
  // cycles as the model says it stalls, then updates the model.
  task automatic access(input bit we, input bit re, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] wa, word, mask;
    int          sh, idx, len;
    bit          mis, ld_ok, st_ok;
    kind_t       kind;
    wa    = {addr[31:2], 2'b00};
    idx   = int'(addr[4:2]);
    word  = rd_mem(wa);
    sh    = int'(addr[1:0]) * 8;
    ld_ok = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_ok = f3 inside {3'b000, 3'b001, 3'b010};
    mis   = ((f3 == 3'b001 || f3 == 3'b101) && addr[0]) || (f3 == 3'b010 && addr[1:0] != 2'b00);
    case (f3)
      3'b000:  mask = 32'hFF << sh;
      3'b001:  mask = 32'hFFFF << sh;
      default: mask = 32'hFFFF_FFFF;
    endcase
    t_resident = res_v[idx] && (res_a[idx] == wa);
    len = 1;
    if (we) begin
      kind = !st_ok ? K_NOP : (mis ? K_MIS : K_ST);
      if (kind == K_ST) len = LAT + 2;
    end else if (re) begin
      kind = !ld_ok ? K_NOP : (mis ? K_MIS : (t_resident ? K_HIT : K_MISS));
      if (kind == K_MISS) len = LAT + 3;
    end else begin
      kind = K_IDLE;
    end
    t_kind      = kind;
    t_addr      = wa;
    t_exp_rdata = model_load(f3, addr[1:0], word);
    t_exp_wdata = (wd << sh) & mask;
    t_exp_wstrb = {mask[24], mask[16], mask[8], mask[0]};
    cpu_we = we; cpu_re = re; cpu_funct3 = f3; cpu_addr = addr; cpu_wdata = wd;
    t_stalls = 0; t_k = 0; t_active = 1;
    repeat (len) @(posedge clk);
    #1;
    t_active = 0; cpu_re = 1'b0; cpu_we = 1'b0;
    if (kind == K_MISS) begin
      res_v[idx] = 1'b1;
      res_a[idx] = wa;
    end
    if (kind == K_ST) mem_model[wa] = (word & ~mask) | ((wd << sh) & mask);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      res_v[i] = 1'b0;
      res_a[i] = 32'h0;
    end
    mem_model[32'h40] = 32'hDEAD_BEEF;
    mem_model[32'h80] = 32'h1122_3344;
    mem_model[32'hC0] = 32'h0BAD_F00D;
    rst_n = 1'b0; cpu_re = 1'b1; cpu_we = 1'b0;
    cpu_addr = 32'h40; cpu_funct3 = 3'b010; cpu_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_mem_wstrb", mem_wstrb, 0);
    chk("reset_cpu_stall", cpu_stall, 0);
    chk("reset_cpu_rdata", cpu_rdata, 0);
    chk("reset_cache_hit", cache_hit, 0);
    cpu_re = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk); #1;

    // Cold load miss with a 3-cycle memory latency.
    access(0, 1, 3'b010, 32'h40, 0);
    chk("lw40_stall_cycles", t_stalls, 5);
    chk("lw40_data", got_rdata, 32'hDEAD_BEEF);
    access(0, 1, 3'b000, 32'h43, 0);
    chk("lb43", got_rdata, 32'hFFFF_FFDE);
    access(0, 1, 3'b100, 32'h43, 0);
    chk("lbu43", got_rdata, 32'h0000_00DE);
    access(0, 1, 3'b101, 32'h42, 0);
    chk("lhu42", got_rdata, 32'h0000_DEAD);

    // Byte store on a hit line, then read back from the cache.
    access(1, 0, 3'b000, 32'h41, 32'h77);
    chk("sb41_wstrb", got_wstrb, 4'b0010);
    chk("sb41_wdata", got_wdata, 32'h0000_7700);
    access(0, 1, 3'b010, 32'h40, 0);
    chk("lw40_after_sb", got_rdata, 32'hDEAD_77EF);

    // A store miss on the shared index does not allocate. A later load evicts.
    access(1, 0, 3'b010, 32'h80, 32'hCAFE_F00D);
    access(0, 1, 3'b010, 32'h40, 0);
    chk("lw40_still_hit", got_rdata, 32'hDEAD_77EF);
    access(0, 1, 3'b010, 32'h80, 0);
    chk("lw80_refill", got_rdata, 32'hCAFE_F00D);
    access(0, 1, 3'b010, 32'h40, 0);
    chk("lw40_evicted_refill", got_rdata, 32'hDEAD_77EF);

    // Misaligned, illegal funct3 and idle cycles.
    access(0, 1, 3'b001, 32'h41, 0);
    access(1, 0, 3'b010, 32'h42, 32'h1234_5678);
    access(1, 0, 3'b100, 32'h40, 32'hFFFF_FFFF);
    access(0, 1, 3'b011, 32'h40, 0);
    access(0, 0, 3'b010, 32'h40, 0);

    // Half and byte lanes in the upper half of a word, and a sign-extended half.
    access(0, 1, 3'b010, 32'h44, 0);
    chk("lw44_default", got_rdata, 32'h5A5A_0044);
    access(1, 0, 3'b001, 32'h46, 32'hFFFF_ABCD);
    chk("sh46_wstrb", got_wstrb, 4'b1100);
    chk("sh46_wdata", got_wdata, 32'hABCD_0000);
    access(0, 1, 3'b001, 32'h46, 0);
    chk("lh46", got_rdata, 32'hFFFF_ABCD);
    access(0, 1, 3'b101, 32'h46, 0);
    chk("lhu46", got_rdata, 32'h0000_ABCD);
    access(0, 1, 3'b000, 32'h47, 0);
    chk("lb47", got_rdata, 32'hFFFF_FFAB);
    access(1, 0, 3'b000, 32'h44, 32'hFFFF_FF80);
    chk("sb44_wdata", got_wdata, 32'h0000_0080);
    access(0, 1, 3'b100, 32'h44, 0);
    chk("lbu44", got_rdata, 32'h0000_0080);
    access(0, 1, 3'b010, 32'h44, 0);
    chk("lw44_merged", got_rdata, 32'hABCD_0080);

    // Reset in the middle of a refill aborts it and leaves the line invalid.
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'hC0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("abort_req_before", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_req_async", mem_req, 0);
    chk("abort_stall", cpu_stall, 0);
    chk("abort_mem_wstrb", mem_wstrb, 0);
    cpu_re = 1'b0;
    for (int i = 0; i < 8; i++) res_v[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(0, 1, 3'b010, 32'hC0, 0);
    chk("lwC0_miss_stalls", t_stalls, 5);
    chk("lwC0_data", got_rdata, 32'h0BAD_F00D);
    access(0, 1, 3'b010, 32'h40, 0);
    chk("lw40_after_reset", got_rdata, 32'hDEAD_77EF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
